// File: rtl/protocol_handler.sv
// Host-side transaction sequencer: issues token/DATA0/handshake packets,
// retries on NAK, bad CRC or reply timeout, and reports one completion pulse.
//   state  | meaning
//   IDLE   | waiting for a request edge
//   O_TOK  | OUT token sent, waiting for tx_done
//   O_DAT  | DATA0 sent, waiting for tx_done
//   O_WAIT | waiting for the device handshake
//   I_TOK  | IN token sent, waiting for tx_done
//   I_WAIT | waiting for device DATA0
//   I_HS   | ACK/NAK sent, waiting for tx_done
//   DONE   | single-cycle completion pulse
module protocol_handler #(
  parameter logic [6:0] DEV_ADDR     = 7'd5,
  parameter logic [3:0] ENDP         = 4'd4,
  parameter int         MAX_ATTEMPTS = 8,
  parameter int         TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_trans,
  input  logic        out_trans,
  input  logic [63:0] data_to_device,
  output logic [63:0] data_from_device,
  output logic        success,
  output logic        failure,
  output logic        tx_valid,
  output logic [3:0]  tx_pid,
  output logic [6:0]  tx_addr,
  output logic [3:0]  tx_endp,
  output logic [63:0] tx_data,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic [63:0] rx_data,
  input  logic        rx_crc_ok
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]      ATT_MAX  = 4'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    IDLE, O_TOK, O_DAT, O_WAIT, I_TOK, I_WAIT, I_HS, DONE
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_out_q, r_in_q;
  logic [3:0]    r_attempt;
  logic [TW-1:0] r_tmo;
  logic          r_tx_valid, r_success, r_failure;
  logic [3:0]    r_tx_pid;
  logic [63:0]   r_tx_data, r_dfd;

  logic          w_start_out, w_start_in, w_tmo_hit;
  logic [3:0]    w_attempt_inc;
  logic          w_send, w_retry, w_succ, w_fail, w_capture, w_latch;
  logic [3:0]    w_send_pid;

  always_comb begin
    w_start_out   = out_trans & ~r_out_q;
    w_start_in    = in_trans & ~r_in_q;
    w_attempt_inc = r_attempt + 4'd1;
    w_tmo_hit     = (r_tmo == TMO_LAST);
    w_state_next  = r_state;
    w_send        = 1'b0;
    w_send_pid    = PID_OUT;
    w_retry       = 1'b0;
    w_succ        = 1'b0;
    w_fail        = 1'b0;
    w_capture     = 1'b0;
    w_latch       = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_start_out) begin
          w_state_next = O_TOK;
          w_send       = 1'b1;
          w_send_pid   = PID_OUT;
          w_capture    = 1'b1;
        end else if (w_start_in) begin
          w_state_next = I_TOK;
          w_send       = 1'b1;
          w_send_pid   = PID_IN;
        end
      end
      O_TOK: begin
        if (tx_done) begin
          w_state_next = O_DAT;
          w_send       = 1'b1;
          w_send_pid   = PID_DATA0;
        end
      end
      O_DAT:  if (tx_done) w_state_next = O_WAIT;
      O_WAIT: begin
        if (rx_valid) begin
          if (rx_crc_ok && rx_pid == PID_ACK) begin
            w_state_next = DONE;
            w_succ       = 1'b1;
          end else begin
            w_retry = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_retry = 1'b1;
        end
      end
      I_TOK:  if (tx_done) w_state_next = I_WAIT;
      I_WAIT: begin
        if (rx_valid) begin
          w_state_next = I_HS;
          w_send       = 1'b1;
          if (rx_crc_ok && rx_pid == PID_DATA0) begin
            w_latch    = 1'b1;
            w_send_pid = PID_ACK;
          end else begin
            w_send_pid = PID_NAK;
          end
        end else if (w_tmo_hit) begin
          w_retry = 1'b1;
        end
      end
      // The handshake just sent tells us whether the IN data was good.
      I_HS: begin
        if (tx_done) begin
          if (r_tx_pid == PID_ACK) begin
            w_state_next = DONE;
            w_succ       = 1'b1;
          end else begin
            w_retry = 1'b1;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    if (w_retry) begin
      if (w_attempt_inc == ATT_MAX) begin
        w_state_next = DONE;
        w_fail       = 1'b1;
      end else begin
        w_send       = 1'b1;
        w_state_next = (r_state == O_WAIT) ? O_TOK : I_TOK;
        w_send_pid   = (r_state == O_WAIT) ? PID_OUT : PID_IN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_out_q    <= 1'b0;
      r_in_q     <= 1'b0;
      r_attempt  <= 4'd0;
      r_tmo      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_pid   <= 4'd0;
      r_tx_data  <= 64'd0;
      r_dfd      <= 64'd0;
      r_success  <= 1'b0;
      r_failure  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_out_q    <= out_trans;
      r_in_q     <= in_trans;
      r_tx_valid <= w_send;
      r_success  <= w_succ;
      r_failure  <= w_fail;
      if (w_send)    r_tx_pid  <= w_send_pid;
      if (w_capture) r_tx_data <= data_to_device;
      if (w_latch)   r_dfd     <= rx_data;
      if (r_state == IDLE)
        r_attempt <= 4'd0;
      else if (w_retry)
        r_attempt <= w_attempt_inc;
      if (r_state == O_WAIT || r_state == I_WAIT)
        r_tmo <= r_tmo + TW'(1);
      else
        r_tmo <= '0;
    end
  end

  assign data_from_device = r_dfd;
  assign success          = r_success;
  assign failure          = r_failure;
  assign tx_valid         = r_tx_valid;
  assign tx_pid           = r_tx_pid;
  assign tx_data          = r_tx_data;
  assign tx_addr          = DEV_ADDR;
  assign tx_endp          = ENDP;

endmodule

// File: tb/tb_protocol_handler.sv
// Directed bench for protocol_handler: a scripted encoder/decoder responder
// plus a queue of expected PIDs checked as each packet is requested.
module tb_protocol_handler;

  localparam logic [3:0] P_OUT   = 4'b0001;
  localparam logic [3:0] P_IN    = 4'b1001;
  localparam logic [3:0] P_DATA0 = 4'b0011;
  localparam logic [3:0] P_ACK   = 4'b0010;
  localparam logic [3:0] P_NAK   = 4'b1010;

  logic        clk = 1'b0;
  logic        rst, in_trans, out_trans;
  logic [63:0] data_to_device, data_from_device;
  logic        success, failure, tx_valid;
  logic [3:0]  tx_pid;
  logic [6:0]  tx_addr;
  logic [3:0]  tx_endp;
  logic [63:0] tx_data;
  logic        tx_done, rx_valid;
  logic [3:0]  rx_pid;
  logic [63:0] rx_data;
  logic        rx_crc_ok;

  always #5 clk = ~clk;

  protocol_handler dut (
    .clk(clk), .rst(rst), .in_trans(in_trans), .out_trans(out_trans),
    .data_to_device(data_to_device), .data_from_device(data_from_device),
    .success(success), .failure(failure), .tx_valid(tx_valid),
    .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp), .tx_data(tx_data),
    .tx_done(tx_done), .rx_valid(rx_valid), .rx_pid(rx_pid),
    .rx_data(rx_data), .rx_crc_ok(rx_crc_ok)
  );

  typedef struct {
    logic [3:0]  pid;
    logic        crc;
    logic [63:0] data;
  } rx_t;

  logic [3:0]  exp_q[$];
  rx_t         rx_q[$];
  int          tv_cyc[$];
  int          n_tests = 0, n_errs = 0;
  int          cyc = 0, done_cnt = 0, rx_cnt = 0, rx_delay = 2;
  int          succ_cnt = 0, fail_cnt = 0, start_cyc = 0;
  logic [3:0]  exp_pending = 4'd0;
  logic [63:0] exp_data = 64'd0, exp_dfd = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the responder, then check whatever the DUT requested.
  task automatic tick();
    rx_t r;
    @(posedge clk);
    #1;
    cyc++;
    tx_done   = 1'b0;
    rx_valid  = 1'b0;
    rx_crc_ok = 1'b0;
    rx_pid    = 4'd0;
    rx_data   = 64'd0;
    if (rx_cnt > 0) begin
      rx_cnt--;
      if (rx_cnt == 0 && rx_q.size() > 0) begin
        r = rx_q.pop_front();
        rx_valid  = 1'b1;
        rx_pid    = r.pid;
        rx_crc_ok = r.crc;
        rx_data   = r.data;
      end
    end
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        tx_done = 1'b1;
        chk("tx_pid held until tx_done", tx_pid, exp_pending);
        if (exp_pending == P_DATA0 || exp_pending == P_IN) rx_cnt = rx_delay;
      end
    end
    if (tx_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious tx_valid", tx_valid, 1'b0);
      end else begin
        exp_pending = exp_q.pop_front();
        chk("tx_pid", tx_pid, exp_pending);
        if (exp_pending == P_DATA0) chk("tx_data", tx_data, exp_data);
        if (exp_pending == P_NAK) chk("dfd held on bad reply", data_from_device, exp_dfd);
        tv_cyc.push_back(cyc);
        done_cnt = 3;
      end
    end
    if (success) succ_cnt++;
    if (failure) fail_cnt++;
  endtask

  task automatic begin_txn();
    succ_cnt = 0;
    fail_cnt = 0;
    tv_cyc.delete();
    start_cyc = cyc + 1;
  endtask

  task automatic run_txn(input string name, input int budget, input int exp_s, input int exp_f);
    int k;
    k = 0;
    while (succ_cnt + fail_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    chk({name, " completion within budget"}, (succ_cnt + fail_cnt) != 0, 1'b1);
    repeat (5) tick();
    chk({name, " success pulses"}, succ_cnt, exp_s);
    chk({name, " failure pulses"}, fail_cnt, exp_f);
    chk({name, " expected packets all sent"}, exp_q.size(), 0);
  endtask

  task automatic go_idle();
    out_trans = 1'b0;
    in_trans  = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; in_trans = 1'b0; out_trans = 1'b0; data_to_device = 64'd0;
    tx_done = 1'b0; rx_valid = 1'b0; rx_pid = 4'd0; rx_data = 64'd0; rx_crc_ok = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("reset success", success, 1'b0);
    chk("reset failure", failure, 1'b0);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset tx_pid", tx_pid, 4'd0);
    chk("reset tx_data", tx_data, 64'd0);
    chk("reset data_from_device", data_from_device, 64'd0);
    chk("tx_addr", tx_addr, 7'd5);
    chk("tx_endp", tx_endp, 4'd4);
    rst = 1'b0;
    repeat (2) tick();

    // OUT happy path, then out_trans held high must not restart
    exp_data = 64'hDEAD_BEEF_0000_1234;
    data_to_device = exp_data;
    exp_q.push_back(P_OUT); exp_q.push_back(P_DATA0);
    rx_q.push_back('{P_ACK, 1'b1, 64'd0});
    begin_txn();
    out_trans = 1'b1;
    tick();
    data_to_device = 64'h0;
    run_txn("out_ok", 100, 1, 0);
    chk("first tx_valid one cycle after start", tv_cyc[0], start_cyc);
    repeat (20) tick();
    chk("held out_trans no restart", tv_cyc.size(), 2);
    go_idle();

    // OUT with persistent NAK
    exp_data = 64'h1111_2222_3333_4444;
    data_to_device = exp_data;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(P_OUT); exp_q.push_back(P_DATA0);
      rx_q.push_back('{P_NAK, 1'b1, 64'd0});
    end
    begin_txn();
    out_trans = 1'b1;
    run_txn("out_nak", 400, 0, 1);
    chk("out_nak packet count", tv_cyc.size(), 16);
    go_idle();

    // IN with a corrupt first reply
    exp_q.push_back(P_IN); exp_q.push_back(P_NAK);
    exp_q.push_back(P_IN); exp_q.push_back(P_ACK);
    rx_q.push_back('{P_DATA0, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0});
    rx_q.push_back('{P_DATA0, 1'b1, 64'h0123_4567_89AB_CDEF});
    begin_txn();
    in_trans = 1'b1;
    run_txn("in_crc", 200, 1, 0);
    chk("in_crc data_from_device", data_from_device, 64'h0123_4567_89AB_CDEF);
    exp_dfd = 64'h0123_4567_89AB_CDEF;
    go_idle();

    // IN timeout: 8 tokens, 259 cycles apart (3-cycle tx_done + 255 wait + 1)
    for (int i = 0; i < 8; i++) exp_q.push_back(P_IN);
    begin_txn();
    in_trans = 1'b1;
    run_txn("in_timeout", 3000, 0, 1);
    chk("in_timeout token count", tv_cyc.size(), 8);
    for (int i = 1; i < 8 && i < tv_cyc.size(); i++)
      chk("in_timeout retry spacing", tv_cyc[i] - tv_cyc[i-1], 259);
    chk("in_timeout data_from_device kept", data_from_device, exp_dfd);
    go_idle();

    // rx_valid landing in the timeout cycle wins
    rx_delay = 255;
    exp_q.push_back(P_IN); exp_q.push_back(P_ACK);
    rx_q.push_back('{P_DATA0, 1'b1, 64'hFEED_FACE_CAFE_0001});
    begin_txn();
    in_trans = 1'b1;
    run_txn("rx_at_timeout", 400, 1, 0);
    chk("rx_at_timeout data", data_from_device, 64'hFEED_FACE_CAFE_0001);
    exp_dfd = 64'hFEED_FACE_CAFE_0001;
    rx_delay = 2;
    go_idle();

    // Simultaneous edges: OUT wins, IN dropped; both held high afterwards
    exp_data = 64'hA5A5_5A5A_0F0F_F0F0;
    data_to_device = exp_data;
    exp_q.push_back(P_OUT); exp_q.push_back(P_DATA0);
    rx_q.push_back('{P_ACK, 1'b1, 64'd0});
    begin_txn();
    out_trans = 1'b1;
    in_trans  = 1'b1;
    run_txn("simultaneous", 100, 1, 0);
    repeat (20) tick();
    chk("simultaneous packet count", tv_cyc.size(), 2);
    go_idle();

    // Reset while waiting for the OUT handshake
    exp_data = 64'h7777_8888_9999_AAAA;
    data_to_device = exp_data;
    exp_q.push_back(P_OUT); exp_q.push_back(P_DATA0);
    begin_txn();
    out_trans = 1'b1;
    for (int k = 0; k < 40 && !(exp_q.size() == 0 && done_cnt == 0); k++) tick();
    repeat (3) tick();
    rst = 1'b1;
    out_trans = 1'b0;
    tick();
    chk("rst state idle", dut.r_state, 0);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_pid", tx_pid, 4'd0);
    chk("rst tx_data", tx_data, 64'd0);
    chk("rst data_from_device", data_from_device, 64'd0);
    chk("rst success", success, 1'b0);
    chk("rst failure", failure, 1'b0);
    rst = 1'b0;
    repeat (300) tick();
    chk("no pulse after reset (success)", succ_cnt, 0);
    chk("no pulse after reset (failure)", fail_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_errs);
    $finish;
  end

endmodule
